// File: rtl/dataflow_regfile.sv
// Dataflow register file: registers, an external port and a preset source
// drive a set of wired-AND precharged buses that can be bridged forward.
// Registers and a 2*WIDTH program counter load from the resolved buses.
// Multiple drivers on the same bus raise a sticky contention flag.
module dataflow_regfile #(
  parameter int unsigned     WIDTH        = 8,
  parameter int unsigned     NUM_REGS     = 8,
  parameter int unsigned     NUM_BUSES    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_BUSES*(NUM_REGS+2)-1:0]      bus_sel,
  input  logic [WIDTH-1:0]                       ext_data,
  input  logic [NUM_BUSES-2:0]                   bridge_en,
  input  logic [NUM_REGS-1:0]                    load_en,
  input  logic [NUM_REGS*$clog2(NUM_BUSES)-1:0]  load_bus,
  input  logic                                   pc_load,
  input  logic                                   pc_inc,
  input  logic                                   pc_dec,
  input  logic                                   err_clr,
  output logic [NUM_BUSES*WIDTH-1:0]             bus_value,
  output logic [NUM_REGS*WIDTH-1:0]              reg_value,
  output logic [2*WIDTH-1:0]                     pc,
  output logic                                   pc_page_cross,
  output logic [NUM_BUSES-1:0]                   contention
);

  localparam int unsigned NSRC = NUM_REGS + 2;
  localparam int unsigned BW   = $clog2(NUM_BUSES);
  localparam int unsigned PW   = 2 * WIDTH;

  logic [NUM_REGS*WIDTH-1:0]  regs_q, regs_d;
  logic [PW-1:0]              pc_q, pc_d;
  logic                       pc_page_cross_q, pc_page_cross_d;
  logic [NUM_BUSES-1:0]       contention_q, contention_d;

  logic [NUM_BUSES*WIDTH-1:0] bus_res;
  logic [NUM_BUSES-1:0]       bus_seen;
  logic [NUM_BUSES-1:0]       bus_multi;
  logic [PW-1:0]              pc_base;
  logic                       inc_only, dec_only;

  // Bus resolution: AND of all active drivers over an all-ones precharge.
  // Direct sources are folded first; bridges are then applied in ascending
  // index order so a bridged value already includes every upstream bridge.
  always_comb begin
    bus_res   = '1;
    bus_seen  = '0;
    bus_multi = '0;
    for (int unsigned b = 0; b < NUM_BUSES; b++) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (bus_sel[b*NSRC + i]) begin
          bus_multi[b] = bus_multi[b] | bus_seen[b];
          bus_seen[b]  = 1'b1;
          bus_res[b*WIDTH +: WIDTH] = bus_res[b*WIDTH +: WIDTH] & regs_q[i*WIDTH +: WIDTH];
        end
      end
      if (bus_sel[b*NSRC + NUM_REGS]) begin
        bus_multi[b] = bus_multi[b] | bus_seen[b];
        bus_seen[b]  = 1'b1;
        bus_res[b*WIDTH +: WIDTH] = bus_res[b*WIDTH +: WIDTH] & ext_data;
      end
      if (bus_sel[b*NSRC + NUM_REGS + 1]) begin
        bus_multi[b] = bus_multi[b] | bus_seen[b];
        bus_seen[b]  = 1'b1;
        bus_res[b*WIDTH +: WIDTH] = bus_res[b*WIDTH +: WIDTH] & PRESET_VALUE;
      end
    end
    for (int unsigned k = 0; k < NUM_BUSES - 1; k++) begin
      if (bridge_en[k]) begin
        bus_multi[k+1] = bus_multi[k+1] | bus_seen[k+1];
        bus_seen[k+1]  = 1'b1;
        bus_res[(k+1)*WIDTH +: WIDTH] = bus_res[(k+1)*WIDTH +: WIDTH]
                                      & bus_res[k*WIDTH +: WIDTH];
      end
    end
  end

  // Register loads; an index that names no existing bus matches nothing, so the register holds.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (load_en[i]) begin
        for (int unsigned b = 0; b < NUM_BUSES; b++) begin
          if (load_bus[i*BW +: BW] == BW'(b)) begin
            regs_d[i*WIDTH +: WIDTH] = bus_res[b*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Program counter next value and low-byte carry/borrow detection.
  always_comb begin
    pc_base         = pc_load ? bus_res[PW-1:0] : pc_q;
    inc_only        = pc_inc & ~pc_dec;
    dec_only        = pc_dec & ~pc_inc;
    pc_d            = pc_base;
    pc_page_cross_d = 1'b0;
    if (inc_only) begin
      pc_d            = pc_base + {{(PW-1){1'b0}}, 1'b1};
      pc_page_cross_d = (pc_base[WIDTH-1:0] == '1);
    end else if (dec_only) begin
      pc_d            = pc_base - {{(PW-1){1'b0}}, 1'b1};
      pc_page_cross_d = (pc_base[WIDTH-1:0] == '0);
    end
  end

  // Sticky contention flags: a new set in the same cycle beats err_clr.
  always_comb begin
    contention_d = (contention_q & ~{NUM_BUSES{err_clr}}) | bus_multi;
  end

  // State registers with synchronous reset overriding every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q          <= {NUM_REGS{RESET_VALUE}};
      pc_q            <= '0;
      pc_page_cross_q <= 1'b0;
      contention_q    <= '0;
    end else begin
      regs_q          <= regs_d;
      pc_q            <= pc_d;
      pc_page_cross_q <= pc_page_cross_d;
      contention_q    <= contention_d;
    end
  end

  assign bus_value     = bus_res;
  assign reg_value     = regs_q;
  assign pc            = pc_q;
  assign pc_page_cross = pc_page_cross_q;
  assign contention    = contention_q;

endmodule

// File: tb/tb_dataflow_regfile.sv
// Directed bench for dataflow_regfile with hand-computed expectations.
module tb_dataflow_regfile;

  localparam int W    = 8;
  localparam int NR   = 8;
  localparam int NB   = 4;
  localparam int NSRC = NR + 2;
  localparam int BW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NB*NSRC-1:0]   bus_sel;
  logic [W-1:0]         ext_data;
  logic [NB-2:0]        bridge_en;
  logic [NR-1:0]        load_en;
  logic [NR*BW-1:0]     load_bus;
  logic                 pc_load, pc_inc, pc_dec, err_clr;
  logic [NB*W-1:0]      bus_value;
  logic [NR*W-1:0]      reg_value;
  logic [2*W-1:0]       pc;
  logic                 pc_page_cross;
  logic [NB-1:0]        contention;

  int n_checks = 0;
  int n_fail   = 0;

  dataflow_regfile #(
    .WIDTH       (W),
    .NUM_REGS    (NR),
    .NUM_BUSES   (NB),
    .RESET_VALUE (8'h00),
    .PRESET_VALUE(8'hFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_sel      (bus_sel),
    .ext_data     (ext_data),
    .bridge_en    (bridge_en),
    .load_en      (load_en),
    .load_bus     (load_bus),
    .pc_load      (pc_load),
    .pc_inc       (pc_inc),
    .pc_dec       (pc_dec),
    .err_clr      (err_clr),
    .bus_value    (bus_value),
    .reg_value    (reg_value),
    .pc           (pc),
    .pc_page_cross(pc_page_cross),
    .contention   (contention)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus_sel   = '0;
    ext_data  = '0;
    bridge_en = '0;
    load_en   = '0;
    load_bus  = '0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_dec    = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic src(input int b, input int s);
    bus_sel[b*NSRC + s] = 1'b1;
  endtask

  task automatic ld(input int r, input int b);
    load_en[r] = 1'b1;
    load_bus[r*BW +: BW] = 2'(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] busv(input int b);
    return bus_value[b*W +: W];
  endfunction

  function automatic logic [7:0] regv(input int r);
    return reg_value[r*W +: W];
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    step();
    check("rst_regs", reg_value, 64'h0);
    check("rst_pc", pc, 16'h0000);
    check("rst_pcc", pc_page_cross, 1'b0);
    check("rst_cont", contention, 4'h0);
    check("rst_bus_undriven", bus_value, 32'hFFFF_FFFF);
    rst = 1'b0;

    // External value onto B2, loaded into R3
    @(negedge clk);
    ext_data = 8'h5A; src(2, NR); ld(3, 2);
    #1;
    check("ld_bus2", busv(2), 8'h5A);
    step();
    check("ld_r3_all_regs", reg_value, 64'h0000_0000_5A00_0000);
    check("ld_no_cont", contention, 4'h0);

    // R0=F0, R1=3C via B0
    @(negedge clk); idle();
    ext_data = 8'hF0; src(0, NR); ld(0, 0);
    step();
    @(negedge clk); idle();
    ext_data = 8'h3C; src(0, NR); ld(1, 0);
    step();
    check("r0_r1", reg_value[15:0], 16'h3CF0);

    // Bridge B0 -> B1 while R1 also drives B1
    @(negedge clk); idle();
    src(0, 0); src(1, 1); bridge_en[0] = 1'b1;
    #1;
    check("bridge_b0", busv(0), 8'hF0);
    check("bridge_b1_and", busv(1), 8'h30);
    step();
    check("cont_set", contention, 4'b0010);
    err_clr = 1'b1;
    step();
    check("cont_set_wins", contention, 4'b0010);
    @(negedge clk); idle();
    err_clr = 1'b1;
    step();
    check("cont_cleared", contention, 4'h0);

    // R0 drives and loads B0: holds its own value
    @(negedge clk); idle();
    src(0, 0); ld(0, 0);
    step();
    check("self_load_r0", regv(0), 8'hF0);

    // Undriven buses precharge to all-ones; load R5 from B0
    @(negedge clk); idle();
    ld(5, 0);
    #1;
    check("undriven_all", bus_value, 32'hFFFF_FFFF);
    step();
    check("undriven_r5", reg_value, 64'h0000_FF00_5A00_3CF0);

    // PC: load 0x00FF (B0 undriven, B1 = ext 00), then increment across page
    @(negedge clk); idle();
    src(1, NR); ext_data = 8'h00; pc_load = 1'b1;
    step();
    check("pc_ld_00ff", pc, 16'h00FF);
    check("pcc_after_load", pc_page_cross, 1'b0);
    @(negedge clk); idle();
    pc_inc = 1'b1;
    step();
    check("pc_inc_0100", pc, 16'h0100);
    check("pcc_inc_carry", pc_page_cross, 1'b1);
    @(negedge clk); idle();
    step();
    check("pc_hold_0100", pc, 16'h0100);
    check("pcc_one_cycle", pc_page_cross, 1'b0);

    // PC: load 0xFFFF, increment wraps, decrement wraps back
    @(negedge clk); idle();
    pc_load = 1'b1;
    step();
    check("pc_ld_ffff", pc, 16'hFFFF);
    @(negedge clk); idle();
    pc_inc = 1'b1;
    step();
    check("pc_wrap_up", pc, 16'h0000);
    check("pcc_wrap_up", pc_page_cross, 1'b1);
    @(negedge clk); idle();
    pc_dec = 1'b1;
    step();
    check("pc_wrap_down", pc, 16'hFFFF);
    check("pcc_wrap_down", pc_page_cross, 1'b1);

    // PC load with increment: R4=0x12 on B1, ext 0x34 on B0
    @(negedge clk); idle();
    ext_data = 8'h12; src(0, NR); ld(4, 0);
    step();
    @(negedge clk); idle();
    ext_data = 8'h34; src(0, NR); src(1, 4); pc_load = 1'b1; pc_inc = 1'b1;
    step();
    check("pc_ld_inc", pc, 16'h1235);
    check("pcc_ld_inc", pc_page_cross, 1'b0);
    @(negedge clk); idle();
    pc_inc = 1'b1; pc_dec = 1'b1;
    step();
    check("pc_inc_dec_hold", pc, 16'h1235);

    // Reset mid-operation: R2=0x77, pc=0x1234, contention on B0
    @(negedge clk); idle();
    ext_data = 8'h77; src(0, NR); ld(2, 0);
    step();
    @(negedge clk); idle();
    ext_data = 8'h34; src(0, NR); src(1, 4); pc_load = 1'b1;
    step();
    check("pre_rst_pc", pc, 16'h1234);
    @(negedge clk); idle();
    ext_data = 8'hAA; src(0, NR); src(0, NR + 1);
    step();
    check("pre_rst_cont", contention, 4'b0001);
    check("pre_rst_regs", reg_value, 64'h0000_FF12_5A77_3CF0);
    @(negedge clk); idle();
    rst = 1'b1; load_en = '1; ext_data = 8'hAA; src(0, NR); src(0, NR + 1);
    src(1, 2); pc_inc = 1'b1;
    step();
    check("rst_mid_regs", reg_value, 64'h0);
    check("rst_mid_pc", pc, 16'h0000);
    check("rst_mid_cont", contention, 4'h0);
    check("rst_bus_from_reg", busv(1), 8'h00);
    @(negedge clk); idle();
    rst = 1'b0; pc_inc = 1'b1;
    step();
    check("post_rst_pc", pc, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
